// File: rtl/vc_sram_adapter_pkg.sv
// Shared constants and the response-entry layout for the SRAM val/rdy adapter.
package vc_sram_adapter_pkg;

    localparam logic c_type_read  = 1'b0;
    localparam logic c_type_write = 1'b1;

    // Widest word and tag the response entry can carry; instances narrower
    // than this zero-extend into the entry and slice back out at the head.
    localparam int c_max_data_nbits   = 64;
    localparam int c_max_opaque_nbits = 16;

    // Responses in flight beyond the s1 stage.
    localparam int c_queue_depth = 3;

    typedef struct packed {
        logic                          msg_type;
        logic [c_max_opaque_nbits-1:0] opaque;
        logic [c_max_data_nbits-1:0]   data;
    } resp_entry_t;

    // Circular pointer advance for the 3-entry queue.
    function automatic logic [1:0] ptr_incr(input logic [1:0] ptr);
        return (ptr == 2'd2) ? 2'd0 : ptr + 2'd1;
    endfunction

endpackage

// File: rtl/vc_sram_resp_queue.sv
// Three-entry circular response queue with simultaneous enqueue/dequeue.
module vc_sram_resp_queue
    import vc_sram_adapter_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        enq_val,
    input  resp_entry_t enq_entry,
    input  logic        deq_rdy,
    output logic        deq_val,
    output resp_entry_t deq_entry,
    output logic [1:0]  count
);

    logic [1:0]  head_reg, head_next;
    logic [1:0]  tail_reg, tail_next;
    logic [1:0]  count_reg, count_next;
    logic        enq_fire, deq_fire;
    resp_entry_t entries_reg [c_queue_depth];

    assign deq_val   = (count_reg != 2'd0);
    assign deq_fire  = deq_val && deq_rdy;
    // A full queue may still take an entry when the head leaves this cycle.
    assign enq_fire  = enq_val && ((count_reg != 2'd3) || deq_fire);
    assign deq_entry = entries_reg[head_reg];
    assign count     = count_reg;

    // Pointer and occupancy update; count holds on simultaneous enq/deq.
    always_comb begin
        head_next  = head_reg;
        tail_next  = tail_reg;
        count_next = count_reg;
        if (enq_fire) tail_next = ptr_incr(tail_reg);
        if (deq_fire) head_next = ptr_incr(head_reg);
        case ({enq_fire, deq_fire})
            2'b10:   count_next = count_reg + 2'd1;
            2'b01:   count_next = count_reg - 2'd1;
            default: count_next = count_reg;
        endcase
    end

    // Control state register; reset empties the queue.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_reg  <= 2'd0;
            tail_reg  <= 2'd0;
            count_reg <= 2'd0;
        end else begin
            head_reg  <= head_next;
            tail_reg  <= tail_next;
            count_reg <= count_next;
        end
    end

    // Payload storage: each slot captures the entry when the tail points at it.
    generate
        for (genvar gi = 0; gi < c_queue_depth; gi++) begin : g_slot
            always_ff @(posedge clk) begin
                if (enq_fire && (tail_reg == 2'(gi))) begin
                    entries_reg[gi] <= enq_entry;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/vc_sram_valrdy_adapter.sv
// Val/rdy request/response front end for a 1-cycle synchronous SRAM.
// Requests issue to the SRAM in their acceptance cycle, sit one cycle in s1
// while the read data returns, then land in a 3-entry response queue.
module vc_sram_valrdy_adapter
    import vc_sram_adapter_pkg::*;
#(
    parameter  int p_data_nbits   = 32,
    parameter  int p_num_entries  = 256,
    parameter  int p_opaque_nbits = 8,
    localparam int c_data_nbytes  = (p_data_nbits + 7) / 8,
    localparam int c_addr_nbits   = $clog2(p_num_entries)
) (
    input  logic                      clk,
    input  logic                      reset,

    input  logic                      req_val,
    output logic                      req_rdy,
    input  logic                      req_type,
    input  logic [p_opaque_nbits-1:0] req_opaque,
    input  logic [c_addr_nbits-1:0]   req_addr,
    input  logic [c_data_nbytes-1:0]  req_byte_en,
    input  logic [p_data_nbits-1:0]   req_data,

    output logic                      resp_val,
    input  logic                      resp_rdy,
    output logic                      resp_type,
    output logic [p_opaque_nbits-1:0] resp_opaque,
    output logic [p_data_nbits-1:0]   resp_data,

    output logic                      sram_read_en,
    output logic [c_addr_nbits-1:0]   sram_read_addr,
    input  logic [p_data_nbits-1:0]   sram_read_data,

    output logic                      sram_write_en,
    output logic [c_data_nbytes-1:0]  sram_write_byte_en,
    output logic [c_addr_nbits-1:0]   sram_write_addr,
    output logic [p_data_nbits-1:0]   sram_write_data
);

    logic                      s1_val_reg;
    logic                      s1_type_reg;
    logic [p_opaque_nbits-1:0] s1_opaque_reg;
    logic [1:0]                q_count;
    logic                      req_fire;
    resp_entry_t               enq_entry;
    resp_entry_t               deq_entry;
    logic                      unused_entry_bits;

    // Space is reserved for s1 so an accepted request always finds a queue
    // slot; depends only on registered state, never on resp_rdy.
    assign req_rdy  = reset && (({1'b0, q_count} + {2'b00, s1_val_reg}) < 3'd3);
    assign req_fire = req_val && req_rdy;

    // Requests go straight to the SRAM in the accept cycle; the type bit
    // keeps the two enables mutually exclusive.
    assign sram_read_en       = req_fire && (req_type == c_type_read);
    assign sram_read_addr     = req_addr;
    assign sram_write_en      = req_fire && (req_type == c_type_write);
    assign sram_write_byte_en = req_byte_en;
    assign sram_write_addr    = req_addr;
    assign sram_write_data    = req_data;

    // In-flight stage: one cycle while the synchronous read completes.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_val_reg    <= 1'b0;
            s1_type_reg   <= c_type_read;
            s1_opaque_reg <= '0;
        end else begin
            s1_val_reg <= req_fire;
            if (req_fire) begin
                s1_type_reg   <= req_type;
                s1_opaque_reg <= req_opaque;
            end
        end
    end

    // Build the queue entry from s1; writes respond with zero data.
    always_comb begin
        enq_entry          = '0;
        enq_entry.msg_type = s1_type_reg;
        enq_entry.opaque   = c_max_opaque_nbits'(s1_opaque_reg);
        if (s1_type_reg == c_type_read) begin
            enq_entry.data = c_max_data_nbits'(sram_read_data);
        end
    end

    vc_sram_resp_queue u_resp_queue (
        .clk       (clk),
        .reset     (reset),
        .enq_val   (s1_val_reg),
        .enq_entry (enq_entry),
        .deq_rdy   (resp_rdy),
        .deq_val   (resp_val),
        .deq_entry (deq_entry),
        .count     (q_count)
    );

    assign resp_type   = deq_entry.msg_type;
    assign resp_opaque = deq_entry.opaque[p_opaque_nbits-1:0];
    assign resp_data   = deq_entry.data[p_data_nbits-1:0];

    // Upper entry bits beyond this instance's widths are always zero.
    assign unused_entry_bits = &{1'b0, deq_entry};

endmodule

// File: tb/tb_vc_sram_valrdy_adapter.sv
// Directed bench for vc_sram_valrdy_adapter with a 16-bit x 5 synchronous
// 1rw SRAM behavioural model and a response scoreboard.
module tb_vc_sram_valrdy_adapter;

    localparam int DW = 16;
    localparam int NE = 5;
    localparam int OW = 8;
    localparam int AW = 3;
    localparam int BW = 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          req_val, req_rdy, req_type;
    logic [OW-1:0] req_opaque;
    logic [AW-1:0] req_addr;
    logic [BW-1:0] req_byte_en;
    logic [DW-1:0] req_data;
    logic          resp_val, resp_rdy, resp_type;
    logic [OW-1:0] resp_opaque;
    logic [DW-1:0] resp_data;
    logic          sram_read_en, sram_write_en;
    logic [AW-1:0] sram_read_addr, sram_write_addr;
    logic [DW-1:0] sram_read_data, sram_write_data;
    logic [BW-1:0] sram_write_byte_en;

    always #5 clk = ~clk;

    vc_sram_valrdy_adapter #(
        .p_data_nbits  (DW),
        .p_num_entries (NE),
        .p_opaque_nbits(OW)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .req_val           (req_val),
        .req_rdy           (req_rdy),
        .req_type          (req_type),
        .req_opaque        (req_opaque),
        .req_addr          (req_addr),
        .req_byte_en       (req_byte_en),
        .req_data          (req_data),
        .resp_val          (resp_val),
        .resp_rdy          (resp_rdy),
        .resp_type         (resp_type),
        .resp_opaque       (resp_opaque),
        .resp_data         (resp_data),
        .sram_read_en      (sram_read_en),
        .sram_read_addr    (sram_read_addr),
        .sram_read_data    (sram_read_data),
        .sram_write_en     (sram_write_en),
        .sram_write_byte_en(sram_write_byte_en),
        .sram_write_addr   (sram_write_addr),
        .sram_write_data   (sram_write_data)
    );

    // vc_SynchronousSRAM_1rw behaviour: byte-enabled write, registered read.
    logic [DW-1:0] sram_mem [NE] = '{default: 16'h0000};
    always @(posedge clk) begin
        if (sram_write_en) begin
            for (int b = 0; b < BW; b++) begin
                if (sram_write_byte_en[b]) sram_mem[sram_write_addr][b*8 +: 8] <= sram_write_data[b*8 +: 8];
            end
        end
        if (sram_read_en) sram_read_data <= sram_mem[sram_read_addr];
    end

    typedef struct packed {
        logic          typ;
        logic [OW-1:0] op;
        logic [DW-1:0] data;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model_mem [NE];
    int            n_checks = 0;
    int            n_errors = 0;
    int            stalls   = 0;
    int            n_resp   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one request and hold it until accepted; the expected response is
    // queued at the sampling point just before the accepting edge.
    task automatic offer(input logic t, input logic [OW-1:0] op, input logic [AW-1:0] addr,
                         input logic [BW-1:0] be, input logic [DW-1:0] data);
        bit done = 1'b0;
        @(posedge clk); #1;
        req_val = 1'b1; req_type = t; req_opaque = op;
        req_addr = addr; req_byte_en = be; req_data = data;
        for (int k = 0; k < 40 && !done; k++) begin
            @(negedge clk);
            if (req_rdy) begin
                done = 1'b1;
                chk("sram_read_en", sram_read_en, !t);
                chk("sram_write_en", sram_write_en, t);
                if (t) begin
                    chk("sram_write_addr", sram_write_addr, addr);
                    chk("sram_write_data", sram_write_data, data);
                    chk("sram_write_byte_en", sram_write_byte_en, be);
                    for (int b = 0; b < BW; b++) begin
                        if (be[b]) model_mem[addr][b*8 +: 8] = data[b*8 +: 8];
                    end
                    exp_q.push_back('{typ: 1'b1, op: op, data: 16'h0000});
                end else begin
                    chk("sram_read_addr", sram_read_addr, addr);
                    exp_q.push_back('{typ: 1'b0, op: op, data: model_mem[addr]});
                end
                $display("req  type=%0d opaque=%h addr=%0d be=%b data=%h", t, op, addr, be, data);
            end else begin
                stalls++;
                @(posedge clk); #1;
            end
        end
        if (!done) chk("req_accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic idle();
        @(posedge clk); #1;
        req_val = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && exp_q.size() != 0; k++) @(negedge clk);
        chk("drain_empty", exp_q.size(), 0);
    endtask

    // Response monitor: pop and compare on every delivered response.
    always @(negedge clk) begin
        exp_t e;
        if (reset && resp_val && resp_rdy) begin
            if (exp_q.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("resp", {resp_type, resp_opaque, resp_data}, e);
                n_resp++;
                $display("resp type=%0d opaque=%h data=%h", resp_type, resp_opaque, resp_data);
            end
        end
        chk("rw_exclusive", sram_read_en & sram_write_en, 0);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        for (int i = 0; i < NE; i++) model_mem[i] = 16'h0000;
        reset = 1'b0; resp_rdy = 1'b0;
        req_val = 1'b1; req_type = 1'b0; req_opaque = '0;
        req_addr = '0; req_byte_en = '0; req_data = '0;

        // Reset state, with a request offered to show it is ignored
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_req_rdy", req_rdy, 0);
        chk("rst_resp_val", resp_val, 0);
        chk("rst_read_en", sram_read_en, 0);
        chk("rst_write_en", sram_write_en, 0);
        @(posedge clk); #1;
        req_val = 1'b0; reset = 1'b1; resp_rdy = 1'b1;
        @(negedge clk);
        chk("rdy_after_reset", req_rdy, 1);
        chk("resp_val_after_reset", resp_val, 0);

        // Write then read addr 0, checking two-cycle latency
        offer(1'b1, 8'h10, 3'd0, 2'b11, 16'haaaa);
        idle();
        @(negedge clk); chk("wr_lat_t1", resp_val, 0);
        @(negedge clk); chk("wr_lat_t2", resp_val, 1);
        chk("wr_resp_type", resp_type, 1);
        chk("wr_resp_data", resp_data, 16'h0000);
        offer(1'b0, 8'h11, 3'd0, 2'b00, 16'h0000);
        idle();
        @(negedge clk); chk("rd_lat_t1", resp_val, 0);
        @(negedge clk); chk("rd_lat_t2", resp_val, 1);
        chk("rd_resp_data", resp_data, 16'haaaa);
        drain();

        // Back-to-back writes and reads at full rate
        stalls = 0; base = n_resp;
        for (int i = 0; i < NE; i++) offer(1'b1, 8'h20 + 8'(i), 3'(i), 2'b11, 16'(i) * 16'h1111);
        for (int i = 0; i < NE; i++) offer(1'b0, 8'h30 + 8'(i), 3'(i), 2'b00, 16'h0000);
        idle();
        drain();
        chk("b2b_stalls", stalls, 0);
        chk("b2b_resp_count", n_resp - base, 10);

        // Partial writes via byte enables
        offer(1'b1, 8'h40, 3'd0, 2'b10, 16'haaaa);
        offer(1'b1, 8'h41, 3'd0, 2'b01, 16'hdddd);
        offer(1'b0, 8'h42, 3'd0, 2'b00, 16'h0000);
        idle();
        @(negedge clk);
        @(negedge clk); chk("partial_rd", resp_data, 16'haadd);
        offer(1'b1, 8'h43, 3'd0, 2'b00, 16'h0123);
        offer(1'b0, 8'h44, 3'd0, 2'b00, 16'h0000);
        idle();
        @(negedge clk);
        @(negedge clk); chk("noen_rd", resp_data, 16'haadd);
        drain();

        // Backpressure: three accepted, fourth held until a dequeue
        @(posedge clk); #1; resp_rdy = 1'b0;
        stalls = 0;
        offer(1'b0, 8'h01, 3'd1, 2'b00, 16'h0000);
        offer(1'b0, 8'h02, 3'd2, 2'b00, 16'h0000);
        offer(1'b0, 8'h03, 3'd3, 2'b00, 16'h0000);
        chk("bp_first3_stalls", stalls, 0);
        @(posedge clk); #1;
        req_val = 1'b1; req_type = 1'b0; req_opaque = 8'h04; req_addr = 3'd4;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_req_rdy", req_rdy, 0);
            chk("bp_resp_stable", {resp_val, resp_type, resp_opaque, resp_data}, {1'b1, 1'b0, 8'h01, model_mem[1]});
        end
        @(posedge clk); #1; resp_rdy = 1'b1;
        @(negedge clk); chk("bp_rdy_registered", req_rdy, 0);
        offer(1'b0, 8'h04, 3'd4, 2'b00, 16'h0000);
        idle();
        drain();

        // Reset mid-operation with two responses queued
        @(posedge clk); #1; resp_rdy = 1'b0;
        offer(1'b0, 8'h50, 3'd1, 2'b00, 16'h0000);
        offer(1'b0, 8'h51, 3'd2, 2'b00, 16'h0000);
        idle();
        @(negedge clk);
        @(negedge clk); chk("pre_reset_resp_val", resp_val, 1);
        @(posedge clk); #1; reset = 1'b0;
        #1;
        chk("midrst_resp_val", resp_val, 0);
        chk("midrst_req_rdy", req_rdy, 0);
        exp_q.delete();
        @(negedge clk); chk("midrst_resp_val_hold", resp_val, 0);
        @(posedge clk); #1; reset = 1'b1; resp_rdy = 1'b1;
        @(negedge clk);
        chk("postrst_req_rdy", req_rdy, 1);
        chk("postrst_resp_val", resp_val, 0);
        offer(1'b0, 8'h52, 3'd0, 2'b00, 16'h0000);
        idle();
        @(negedge clk);
        @(negedge clk); chk("postrst_rd_data", resp_data, 16'haadd);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
